// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for bit_serializer.
// The optional parity tracker is enabled by BIT_SERIALIZER_PARITY_TRACK_EN.
package bit_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // A freshly reset parity flag means "even count" (zero occurrences so far).
    localparam logic EVEN_ZERO_RST = 1'b1;
    localparam logic EVEN_ONE_RST  = 1'b1;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/ser_parity_track.sv
// Tracks ones/zeros parity of the word being serialized and latches it on the last bit.
// Only built when BIT_SERIALIZER_PARITY_TRACK_EN is defined.
`ifdef BIT_SERIALIZER_PARITY_TRACK_EN
module ser_parity_track
    import bit_serializer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic fire,
    input  logic ser_bit,
    input  logic last,
    output logic word_even_zero,
    output logic word_even_one
);

    logic ones_even_reg;
    logic zeros_even_reg;
    logic ones_even_next;
    logic zeros_even_next;

    // Parity including the bit being consumed this cycle.
    assign ones_even_next  = ones_even_reg ^ ser_bit;
    assign zeros_even_next = zeros_even_reg ^ ~ser_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ones_even_reg  <= EVEN_ONE_RST;
            zeros_even_reg <= EVEN_ZERO_RST;
            word_even_one  <= EVEN_ONE_RST;
            word_even_zero <= EVEN_ZERO_RST;
        end else begin
            // A back-to-back reload coincides with the previous word's last fire;
            // the new word starts clean while the flags take the finished word.
            if (clear) begin
                ones_even_reg  <= 1'b1;
                zeros_even_reg <= 1'b1;
            end else if (fire) begin
                ones_even_reg  <= ones_even_next;
                zeros_even_reg <= zeros_even_next;
            end
            if (fire && last) begin
                word_even_one  <= ones_even_next;
                word_even_zero <= zeros_even_next;
            end
        end
    end

endmodule
`endif

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with valid/ready load, stall and last-bit framing.
// Define BIT_SERIALIZER_PARITY_TRACK_EN to add the word_even_zero/word_even_one outputs.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             bit_last,
`ifdef BIT_SERIALIZER_PARITY_TRACK_EN
    output logic             word_even_zero,
    output logic             word_even_one,
`endif
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(WIDTH - 1);

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  shreg_reg, shreg_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [WIDTH-1:0]  shreg_shifted;
    logic              head_bit;
    logic              cnt_zero;
    logic              in_shift;
    logic              handshake;
    logic              fire;

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign head_bit      = shreg_reg[WIDTH-1];
            assign shreg_shifted = {shreg_reg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign head_bit      = shreg_reg[0];
            assign shreg_shifted = {1'b0, shreg_reg[WIDTH-1:1]};
        end
    endgenerate

    assign in_shift   = (state_reg == SHIFT);
    assign cnt_zero   = (cnt_reg == '0);
    assign fire       = in_shift && shift_en;
    assign load_ready = !in_shift || (cnt_zero && shift_en);
    assign handshake  = load_valid && load_ready;

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (handshake) begin
                    shreg_next = load_data;
                    cnt_next   = CNT_FIRST;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (!cnt_zero) begin
                        shreg_next = shreg_shifted;
                        cnt_next   = cnt_reg - CNT_W'(1);
                    end else if (handshake) begin
                        shreg_next = load_data;
                        cnt_next   = CNT_FIRST;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Gated by state so the line idles low even though the register keeps its last bit.
    assign bit_out   = in_shift && head_bit;
    assign bit_valid = in_shift;
    assign bit_last  = in_shift && cnt_zero;
    assign busy      = in_shift;

`ifdef BIT_SERIALIZER_PARITY_TRACK_EN
    ser_parity_track u_parity (
        .clk            (clk),
        .rst            (rst),
        .clear          (handshake),
        .fire           (fire),
        .ser_bit        (head_bit),
        .last           (cnt_zero),
        .word_even_zero (word_even_zero),
        .word_even_one  (word_even_one)
    );
`endif

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer: one MSB-first and one LSB-first instance
// driven in lockstep. Parity-flag checks are active when BIT_SERIALIZER_PARITY_TRACK_EN is defined.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       shift_en = 1'b0;

    logic ready_m, bo_m, bv_m, bl_m, busy_m;
    logic ready_l, bo_l, bv_l, bl_l, busy_l;
`ifdef BIT_SERIALIZER_PARITY_TRACK_EN
    logic ez_m, eo_m, ez_l, eo_l;
`endif

    int errors = 0;
    int checks = 0;
    logic exp_ez = 1'b1;
    logic exp_eo = 1'b1;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .load_valid     (load_valid),
        .load_ready     (ready_m),
        .load_data      (load_data),
        .shift_en       (shift_en),
        .bit_out        (bo_m),
        .bit_valid      (bv_m),
        .bit_last       (bl_m),
`ifdef BIT_SERIALIZER_PARITY_TRACK_EN
        .word_even_zero (ez_m),
        .word_even_one  (eo_m),
`endif
        .busy           (busy_m)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
        .clk            (clk),
        .rst            (rst),
        .load_valid     (load_valid),
        .load_ready     (ready_l),
        .load_data      (load_data),
        .shift_en       (shift_en),
        .bit_out        (bo_l),
        .bit_valid      (bv_l),
        .bit_last       (bl_l),
`ifdef BIT_SERIALIZER_PARITY_TRACK_EN
        .word_even_zero (ez_l),
        .word_even_one  (eo_l),
`endif
        .busy           (busy_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " bit_valid"}, 32'(bv_m), 32'd0);
        chk({tag, " busy"}, 32'(busy_m), 32'd0);
        chk({tag, " bit_out"}, 32'(bo_m), 32'd0);
        chk({tag, " bit_last"}, 32'(bl_m), 32'd0);
        chk({tag, " lsb bit_valid"}, 32'(bv_l), 32'd0);
        chk({tag, " lsb busy"}, 32'(busy_l), 32'd0);
    endtask

    task automatic check_bit(input string tag, input logic [7:0] w, input int i, input logic exp_last);
        chk($sformatf("%s msb bit%0d", tag, i), 32'(bo_m), 32'(w[7-i]));
        chk($sformatf("%s lsb bit%0d", tag, i), 32'(bo_l), 32'(w[i]));
        chk($sformatf("%s valid%0d", tag, i), 32'(bv_m && bv_l), 32'd1);
        chk($sformatf("%s last%0d", tag, i), 32'(bl_m), 32'(exp_last));
        chk($sformatf("%s lsb last%0d", tag, i), 32'(bl_l), 32'(exp_last));
        chk($sformatf("%s busy%0d", tag, i), 32'(busy_m), 32'd1);
    endtask

    task automatic chk_flags(input string tag);
`ifdef BIT_SERIALIZER_PARITY_TRACK_EN
        chk({tag, " even_zero"}, 32'(ez_m), 32'(exp_ez));
        chk({tag, " even_one"}, 32'(eo_m), 32'(exp_eo));
        chk({tag, " lsb even_zero"}, 32'(ez_l), 32'(exp_ez));
        chk({tag, " lsb even_one"}, 32'(eo_l), 32'(exp_eo));
`else
        $display("flags %s not built", tag);
`endif
    endtask

    // Expected word parity derived by counting bits.
    task automatic set_exp_flags(input logic [7:0] w);
        int ones;
        ones = $countones(w);
        exp_eo = (ones % 2) == 0;
        exp_ez = ((8 - ones) % 2) == 0;
    endtask

    task automatic send_word(input logic [7:0] w, input string tag);
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = w;
        shift_en   = 1'b1;
        #1 chk({tag, " ready"}, 32'(ready_m), 32'd1);
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_bit(tag, w, i, i == 7);
            chk_flags({tag, " hold"});
            @(negedge clk);
        end
        check_idle({tag, " after"});
        set_exp_flags(w);
        chk_flags({tag, " done"});
        $display("word %s %02h serialized", tag, w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_idle("reset");
        chk("reset ready", 32'(ready_m), 32'd1);
        chk_flags("reset");
        rst = 1'b1;
        $display("reset released");

        // Idle with no load
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("idle ready c%0d", c), 32'(ready_m), 32'd1);
            chk($sformatf("idle valid c%0d", c), 32'(bv_m), 32'd0);
            chk($sformatf("idle busy c%0d", c), 32'(busy_m), 32'd0);
        end
        $display("idle 10 cycles checked");

        send_word(8'hA5, "a5");

        // Back-to-back F0 then 0F, load_valid held across the boundary
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 8'hF0;
        shift_en   = 1'b1;
        @(negedge clk);
        load_data  = 8'h0F;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) load_valid = 1'b0;
            #1;
            if (i == 3) chk("b2b ready mid", 32'(ready_m), 32'd0);
            if (i == 7) chk("b2b ready last", 32'(ready_m), 32'd1);
            check_bit("b2b", (i < 8) ? 8'hF0 : 8'h0F, i % 8, (i % 8) == 7);
            @(negedge clk);
        end
        check_idle("b2b after");
        set_exp_flags(8'h0F);
        chk_flags("b2b done");
        $display("word b2b f0/0f serialized");

        // 81 with a 3-cycle stall while bit 2 is presented: bit_last on cycle 11
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 8'h81;
        shift_en   = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            int idx;
            shift_en = !(cyc >= 3 && cyc <= 5);
            idx = (cyc <= 2) ? cyc - 1 : ((cyc <= 6) ? 2 : cyc - 4);
            #1;
            check_bit($sformatf("stall c%0d", cyc), 8'h81, idx, idx == 7);
            if (!shift_en) chk($sformatf("stall ready c%0d", cyc), 32'(ready_m), 32'd0);
            @(negedge clk);
        end
        check_idle("stall after");
        set_exp_flags(8'h81);
        chk_flags("stall done");
        $display("word stall 81 serialized");

        // Asynchronous reset while bit 4 of 3C is presented
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 8'h3C;
        shift_en   = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check_bit("abort", 8'h3C, 4, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_idle("abort async");
        chk("abort ready", 32'(ready_m), 32'd1);
        exp_ez = 1'b1;
        exp_eo = 1'b1;
        chk_flags("abort");
        @(negedge clk);
        rst = 1'b1;
        $display("abort reset checked");

        send_word(8'h01, "01");
        send_word(8'h03, "03");
        send_word(8'h07, "07");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
